// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, counter sizing and decimal digit-count functions.
package bin_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..v-1.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   // Decimal digits needed for the largest bw-bit unsigned value.
   function automatic int digits_needed(input int bw);
      longint unsigned m;
      int d;
      m = (64'd1 << bw) - 64'd1;
      d = 1;
      while (m >= 64'd10) begin
         m = m / 64'd10;
         d = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Ports: d = digit before the shift, q = corrected digit (combinational).
module bcd_digit_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Ports: clk, tr (async reset), in_valid/in_ready/bin_in, out_valid/out_ready/bcd_out, neg, overflow.
module bin_bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  tr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  neg,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = clog2(BIN_W + 1);

   state_t           st;
   state_t           st_n;
   logic [BIN_W-1:0] mag;
   logic [BIN_W-1:0] mag_in;
   logic             sgn;
   logic             sgn_in;
   logic [BW-1:0]    acc;
   logic [BW-1:0]    adj;
   logic [BW-1:0]    acc_n;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic             carry;
   logic             accept;
   logic             last;

   if (digits_needed(BIN_W) <= DIGITS) begin : g_ovf_note
      $info("bin_bcd_seq: %0d digits cover %0d-bit input, overflow stays 0",
            DIGITS, BIN_W);
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_adj u_adj (
         .d (acc[4*g +: 4]),
         .q (adj[4*g +: 4])
      );
   end

   // Most negative input negates to itself, which is the correct unsigned magnitude.
   assign sgn_in = (SIGNED != 0) && bin_in[BIN_W-1];
   assign mag_in = sgn_in ? -bin_in : bin_in;

   // A bit leaving the top digit is a decimal carry past the last digit.
   assign acc_n  = {adj[BW-2:0], mag[BIN_W-1]};
   assign carry  = adj[BW-1];
   assign last   = (cnt == CW'(1));
   assign accept = (st == IDLE) && in_valid;

   always_ff @(posedge clk or posedge tr) begin
      if (tr) begin
         st <= IDLE;
      end else begin
         st <= st_n;
      end
   end

   always_comb begin
      st_n      = st;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (st)
         IDLE: begin
            in_ready = ~tr;
            if (in_valid) st_n = CONV;
         end
         CONV: begin
            if (last) st_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) st_n = IDLE;
         end
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge tr) begin
      if (tr) begin
         mag      <= '0;
         sgn      <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         bcd_out  <= '0;
         neg      <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         mag <= mag_in;
         sgn <= sgn_in;
         acc <= '0;
         ovf <= 1'b0;
         cnt <= CW'(BIN_W);
      end else if (st == CONV) begin
         mag <= mag << 1;
         acc <= acc_n;
         ovf <= ovf | carry;
         cnt <= cnt - CW'(1);
         // Result registers only change when a conversion completes.
         if (last) begin
            bcd_out  <= acc_n;
            neg      <= sgn;
            overflow <= ovf | carry;
         end
      end
   end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq over three parameter sets.
// Drives table vectors, handshake corner cases, async reset and random operands.
module tb_bin_bcd_seq;

   logic        clk = 1'b0;
   logic        tr;
   logic [2:0]  iv, irdy, ovl, ordy, ng, of;
   logic [12:0] bin0, bin1;
   logic [7:0]  bin2;
   logic [15:0] bcd0, bcd2;
   logic [11:0] bcd1;
   int          ncmp = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   bin_bcd_seq #(.BIN_W(13), .DIGITS(4), .SIGNED(0)) u_d0 (
      .clk(clk), .tr(tr), .in_valid(iv[0]), .in_ready(irdy[0]), .bin_in(bin0),
      .out_valid(ovl[0]), .out_ready(ordy[0]), .bcd_out(bcd0), .neg(ng[0]),
      .overflow(of[0]));

   bin_bcd_seq #(.BIN_W(13), .DIGITS(3), .SIGNED(0)) u_d1 (
      .clk(clk), .tr(tr), .in_valid(iv[1]), .in_ready(irdy[1]), .bin_in(bin1),
      .out_valid(ovl[1]), .out_ready(ordy[1]), .bcd_out(bcd1), .neg(ng[1]),
      .overflow(of[1]));

   bin_bcd_seq #(.BIN_W(8), .DIGITS(4), .SIGNED(1)) u_d2 (
      .clk(clk), .tr(tr), .in_valid(iv[2]), .in_ready(irdy[2]), .bin_in(bin2),
      .out_valid(ovl[2]), .out_ready(ordy[2]), .bcd_out(bcd2), .neg(ng[2]),
      .overflow(of[2]));

   typedef struct {
      int          d;
      logic [12:0] b;
      logic [15:0] bcd;
      logic        neg;
      logic        ovf;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int bw(input int d);
      return (d == 2) ? 8 : 13;
   endfunction

   function automatic int dg(input int d);
      return (d == 1) ? 3 : 4;
   endfunction

   function automatic logic [15:0] get_bcd(input int d);
      case (d)
         0:       return bcd0;
         1:       return {4'h0, bcd1};
         default: return bcd2;
      endcase
   endfunction

   task automatic set_bin(input int d, input logic [12:0] b);
      case (d)
         0:       bin0 = b;
         1:       bin1 = b;
         default: bin2 = b[7:0];
      endcase
   endtask

   // Plain decimal arithmetic on the operand value.
   task automatic model(input int d, input logic [12:0] b,
                        output logic [15:0] r, output logic n, output logic o);
      longint v, mag, lim;
      int w;
      w = bw(d);
      v = longint'(b) & ((longint'(1) << w) - 1);
      n = 1'b0;
      mag = v;
      if (d == 2 && v >= (longint'(1) << (w - 1))) begin
         n = 1'b1;
         mag = (longint'(1) << w) - v;
      end
      lim = 1;
      for (int i = 0; i < dg(d); i++) lim = lim * 10;
      o = (mag >= lim);
      mag = mag % lim;
      r = '0;
      for (int i = 0; i < dg(d); i++) begin
         r[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
   endtask

   task automatic xfer(input int d, input logic [12:0] b, input int hold,
                       input logic [15:0] er, input logic en, input logic eo,
                       input string tag);
      int k;
      int seen;
      @(negedge clk);
      set_bin(d, b);
      iv[d] = 1'b1;
      ordy[d] = (hold == 0);
      k = 0;
      while (!irdy[d] && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " accept"}, 32'(irdy[d]), 32'd1);
      @(negedge clk);
      iv[d] = 1'b0;
      set_bin(d, ~b);
      k = 1;
      seen = 0;
      while (!ovl[d] && k < 100) begin
         seen += int'(irdy[d]);
         @(negedge clk);
         k++;
      end
      chk({tag, " valid"}, 32'(ovl[d]), 32'd1);
      chk({tag, " latency"}, k, bw(d) + 1);
      chk({tag, " busy_ready"}, seen + int'(irdy[d]), 0);
      chk({tag, " bcd"}, 32'(get_bcd(d)), 32'(er));
      chk({tag, " neg"}, 32'(ng[d]), 32'(en));
      chk({tag, " ovf"}, 32'(of[d]), 32'(eo));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold"}, {15'd0, ovl[d], get_bcd(d)}, {15'd0, 1'b1, er});
      end
      ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      chk({tag, " released"}, 32'(ovl[d]), 32'd0);
      chk({tag, " ready_after"}, 32'(irdy[d]), 32'd1);
      @(negedge clk);
      chk({tag, " idle_hold"}, {15'd0, ovl[d], get_bcd(d)}, {16'd0, er});
   endtask

   task automatic rxfer(input int d, input logic [12:0] b, input int hold, input string tag);
      logic [15:0] r;
      logic n, o;
      model(d, b, r, n, o);
      xfer(d, b, hold, r, n, o, tag);
   endtask

   task automatic wait_valid(input string tag, input logic [15:0] er);
      int k;
      int seen;
      k = 1;
      seen = 0;
      while (!ovl[0] && k < 100) begin
         seen += int'(irdy[0]);
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, k, 14);
      chk({tag, " busy_ready"}, seen, 0);
      chk({tag, " bcd"}, 32'(bcd0), 32'(er));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      vt[0]  = '{0, 13'd17,   16'h0017, 1'b0, 1'b0};
      vt[1]  = '{0, 13'd0,    16'h0000, 1'b0, 1'b0};
      vt[2]  = '{0, 13'd8191, 16'h8191, 1'b0, 1'b0};
      vt[3]  = '{0, 13'd1000, 16'h1000, 1'b0, 1'b0};
      vt[4]  = '{1, 13'd8191, 16'h0191, 1'b0, 1'b1};
      vt[5]  = '{1, 13'd999,  16'h0999, 1'b0, 1'b0};
      vt[6]  = '{1, 13'd1000, 16'h0000, 1'b0, 1'b1};
      vt[7]  = '{2, 13'h080,  16'h0128, 1'b1, 1'b0};
      vt[8]  = '{2, 13'h07F,  16'h0127, 1'b0, 1'b0};
      vt[9]  = '{2, 13'h000,  16'h0000, 1'b0, 1'b0};
      vt[10] = '{2, 13'h0FF,  16'h0001, 1'b1, 1'b0};

      tr = 1'b1;
      iv = '0;
      ordy = '0;
      bin0 = '0;
      bin1 = '0;
      bin2 = '0;
      #1;
      chk("rst in_ready", 32'(irdy), 32'd0);
      chk("rst out_valid", 32'(ovl), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst bcd", {bcd0, 4'h0, bcd1}, 32'd0);
      chk("rst flags", {26'd0, ng, of}, 32'd0);
      tr = 1'b0;
      #1;
      chk("rel in_ready", 32'(irdy), 32'd7);

      // Back-to-back with in_valid held; operand changes right after accept.
      @(negedge clk);
      bin0 = 13'd255;
      iv[0] = 1'b1;
      ordy[0] = 1'b1;
      k = 0;
      while (!irdy[0] && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      bin0 = 13'd8191;
      wait_valid("b2b first", 16'h0255);
      @(negedge clk);
      chk("b2b ready_after", 32'(irdy[0]), 32'd1);
      chk("b2b valid_drop", 32'(ovl[0]), 32'd0);
      @(negedge clk);
      iv[0] = 1'b0;
      wait_valid("b2b second", 16'h8191);
      @(negedge clk);
      ordy[0] = 1'b0;
      chk("b2b ready_after2", 32'(irdy[0]), 32'd1);

      xfer(0, 13'd1234, 10, 16'h1234, 1'b0, 1'b0, "backpressure");

      foreach (vt[i]) begin
         xfer(vt[i].d, vt[i].b, i % 3, vt[i].bcd, vt[i].neg, vt[i].ovf,
              $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 45; i++) begin
         int d;
         logic [12:0] b;
         d = i % 3;
         b = (d == 2) ? 13'($urandom_range(0, 255)) : 13'($urandom_range(0, 8191));
         rxfer(d, b, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      end

      // Async reset in the middle of a conversion, with nonzero held results.
      rxfer(1, 13'd8191, 0, "pre_rst1");
      rxfer(0, 13'd4095, 0, "pre_rst0");
      @(negedge clk);
      bin0 = 13'd4095;
      iv[0] = 1'b1;
      k = 0;
      while (!irdy[0] && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      tr = 1'b1;
      #1;
      chk("arst out_valid", 32'(ovl[0]), 32'd0);
      chk("arst bcd0", 32'(bcd0), 32'd0);
      chk("arst bcd1", 32'(bcd1), 32'd0);
      chk("arst ovf", 32'(of[1]), 32'd0);
      chk("arst in_ready", 32'(irdy[0]), 32'd0);
      @(negedge clk);
      tr = 1'b0;
      #1;
      chk("arst rel_ready", 32'(irdy[0]), 32'd1);
      xfer(0, 13'd42, 0, 16'h0042, 1'b0, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
